// File: rtl/ir_pio_capture_if.sv
// Avalon-MM slave bus bundle for ir_pio_capture: register select,
// write strobe/data and registered read data.
interface ir_pio_capture_if #(
    parameter int WIDTH = 1
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/ir_pio_capture.sv
// ir_pio_capture: WIDTH-bit Avalon-MM input port with two-flop
// synchroniser, per-bit glitch filter, edge capture (W1C) and a
// maskable level interrupt.

// Per-bit front end: synchroniser, persistence filter and edge event.
module ir_pio_capture_bit #(
    parameter int EDGE_TYPE     = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic filt,
    output logic evt
);
    // 0 and 1 both mean "accept after one clock", i.e. no filtering
    localparam int NF = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
    localparam int CW = $clog2(NF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NF - 1);

    logic          s1;
    logic          s2;
    logic          prev;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;

    // two-flop synchroniser for the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in_bit;
            s2 <= s1;
        end
    end

    // accept s2 only once it has disagreed with filt for NF straight clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= s2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // one-clock history of the filtered level for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= filt;
    end

    // select which filtered transition counts as a capture event
    always_comb begin
        rise = filt & ~prev;
        fall = ~filt & prev;
        case (EDGE_TYPE)
            0:       evt = rise;
            1:       evt = fall;
            default: evt = rise | fall;
        endcase
    end
endmodule

module ir_pio_capture #(
    parameter int WIDTH         = 1,
    parameter int EDGE_TYPE     = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ir_pio_capture_if.slave       bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RSVD = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_ECAP = 2'd3;

    // decoded bus write for this cycle
    typedef struct packed {
        logic             mask_wr;
        logic             cap_clr;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t          wreq;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;

    // bits are independent: one front end per input bit
    ir_pio_capture_bit #(
        .EDGE_TYPE     (EDGE_TYPE),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_bit [WIDTH-1:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port),
        .filt    (filt),
        .evt     (evt)
    );

    // decode a write strobe into per-register requests
    always_comb begin
        wreq      = '0;
        wreq.data = bus.writedata;
        if (bus.chipselect && !bus.write_n) begin
            wreq.mask_wr = (bus.address == A_MASK);
            wreq.cap_clr = (bus.address == A_ECAP);
        end
        clr_bits = wreq.cap_clr ? wreq.data : '0;
    end

    // interrupt enable register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          irq_mask <= '0;
        else if (wreq.mask_wr) irq_mask <= wreq.data;
    end

    // sticky edge capture; a same-cycle event beats the W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cap <= '0;
        else          edge_cap <= (edge_cap & ~clr_bits) | evt;
    end

    // registered read mux, updated every clock regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                A_DATA: bus.readdata <= filt;
                A_RSVD: bus.readdata <= '0;
                A_MASK: bus.readdata <= irq_mask;
                A_ECAP: bus.readdata <= edge_cap;
            endcase
        end
    end

    // level interrupt straight from registers, so no combinational glitches
    assign irq = |(edge_cap & irq_mask);
endmodule
